fpu_div: RTL and testbench
==========================

Name: fpu_div

Overview:
Multi-cycle IEEE-754-style floating-point divider; the inverse companion to the combinational add/multiply FPU.
Supports half (1/5/10) and single (1/8/23) precision with the same operand packing and the same {neg, zero, carry, overflow} flag layout as the FPU.
Uses a restoring mantissa divider that produces one quotient bit per cycle and has a start/done handshake.
Sits beside the FPU in the execute stage; the controller stalls while busy is high.

Parameters:
- SP_FRAC, 23, single-precision fraction width
- HP_FRAC, 10, half-precision fraction width
- SP_BIAS, 127, single-precision exponent bias
- HP_BIAS, 15, half-precision exponent bias

Ports:
- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state and outputs
- start  in  1  request a division; sampled only in IDLE
- prec  in  1  0 = half (operands in [15:0]), 1 = single; captured on start
- a  in  32  dividend
- b  in  32  divisor
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse; Result/FPUFlags valid from this cycle on
- Result  out  32  quotient; half mode drives [31:16] = 0
- FPUFlags  out  4  {neg, zero, carry, overflow}; carry is always 0

Behaviour:
- Reset values: busy=0, done=0, Result=0, FPUFlags=0, state=IDLE. Reset mid-operation aborts the division with no done pulse.
- Field extraction matches the FPU. Significands carry a hidden 1: 24 bits single, 11 bits half. Zero test is a==0 / b==0 on the active width only; half mode ignores [31:16].
- States: IDLE, DIV, NORM, DONE.
- IDLE: start=1 latches prec, sign = sA^sB, signed 10-bit expT = eA - eB + bias, rem = mA, cnt = N+2 (N = 23 or 10).
  - b==0 goes to DONE with Result = {sign, exp all ones, frac 0} and overflow=1. This takes precedence over a==0.
  - Otherwise a==0 goes to DONE with Result = 0.
  - All other operands go to DIV.
- DIV, each cycle:
  - If rem >= mB: q = {q,1} and rem = (rem - mB) << 1.
  - Else: q = {q,0} and rem = rem << 1.
  - cnt decrements each cycle; at cnt==1 go to NORM. DIV lasts exactly N+2 cycles (25 single, 12 half).
- NORM:
  - If q[N+1]=1: frac = q[N:1], exp = expT.
  - Else: frac = q[N-1:0], exp = expT - 1.
  - Rounding is truncation, same as the FPU.
  - exp >= max (255 / 31) gives signed infinity with overflow=1.
  - exp <= 0 flushes to Result = 0; the sign is dropped.
  - Go to DONE.
- DONE: done=1 and busy=0 for one cycle, then IDLE. Result and FPUFlags hold until the next accepted start.
- Flags are computed from the final Result:
  - neg = sign bit of the active width
  - zero = (Result==0)
  - carry = 0
  - overflow as defined above
- Latency, with start sampled at edge k:
  - normal operation: done high after edge k+N+4, i.e. 27 cycles single, 14 cycles half
  - zero or divide-by-zero: done high after edge k+1
- start while busy or done is high is ignored, with no queuing. Operand changes after acceptance have no effect.

Decomposition:
- Package fpu_pkg holds:
  - precision encoding (PREC_HALF=0, PREC_SINGLE=1)
  - fraction widths, exponent widths, biases
  - exponent-max constants
  - state enum {IDLE, DIV, NORM, DONE}
  - flag bit indices (shared with the FPU)
- Sub-module mant_div: 24-bit restoring shift/subtract datapath (rem, q, cnt) with load/step inputs. fpu_div keeps the FSM, exponent path, special cases and packing.

Test Plan:
- Single 6.0/2.0: a=0x40C00000, b=0x40000000 -> Result=0x40400000, flags=0000, done 27 cycles after start.
- Single 1.0/3.0: a=0x3F800000, b=0x40400000 -> Result=0x3EAAAAAA (truncated), flags=0000.
- Half 3.0/-1.5: prec=0, a=0x00004200, b=0x0000BE00 -> Result=0x0000C000, neg=1, done after 14 cycles.
- Special cases (single):
  - a=0x3F800000, b=0 -> Result=0x7F800000, overflow=1.
  - a=0, b=0x40000000 -> Result=0, zero=1.
  - Both finish with done one cycle after start.
- Overflow/underflow (single):
  - a=0x7F000000, b=0x3E800000 -> Result=0x7F800000, overflow=1.
  - a=0x00800000, b=0x40000000 -> Result=0, zero=1.
- Handshake/reset:
  - start re-pulsed with new operands mid-DIV -> ignored; the original quotient is returned.
  - reset asserted mid-DIV -> busy=0, Result=0 immediately, no done pulse; the next start completes normally.

Source files
------------

// File: rtl/fpu_pkg.sv
// Shared FPU definitions: precision encoding, field widths, biases, flag layout
// and the operand pack/unpack helpers used by the divider.
package fpu_pkg;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned FLAG_W  = 4;
  localparam int unsigned SP_FRAC = 23;
  localparam int unsigned HP_FRAC = 10;
  localparam int unsigned SP_EXP  = 8;
  localparam int unsigned HP_EXP  = 5;
  localparam int unsigned SP_BIAS = 127;
  localparam int unsigned HP_BIAS = 15;
  localparam int unsigned SP_EMAX = 255;
  localparam int unsigned HP_EMAX = 31;
  localparam int unsigned MANT_W  = SP_FRAC + 1;
  localparam int unsigned Q_W     = SP_FRAC + 2;
  localparam int unsigned CNT_W   = 5;
  localparam int unsigned EXPT_W  = 10;

  localparam logic PREC_HALF   = 1'b0;
  localparam logic PREC_SINGLE = 1'b1;

  localparam int unsigned FLAG_NEG   = 3;
  localparam int unsigned FLAG_ZERO  = 2;
  localparam int unsigned FLAG_CARRY = 1;
  localparam int unsigned FLAG_OVF   = 0;

  typedef enum logic [1:0] {IDLE, DIV, NORM, DONE} div_state_e;

  typedef struct packed {
    logic                 sign;
    logic [SP_EXP-1:0]    exp;
    logic [MANT_W-1:0]    mant;
    logic                 zero;
  } fp_fields_t;

  // Half operands live in [15:0]; the upper half is ignored entirely.
  function automatic fp_fields_t fp_unpack(logic prec, logic [DATA_W-1:0] x);
    fp_fields_t f;
    if (prec == PREC_SINGLE) begin
      f.sign = x[31];
      f.exp  = x[30:23];
      f.mant = {1'b1, x[22:0]};
      f.zero = (x == '0);
    end else begin
      f.sign = x[15];
      f.exp  = {3'b000, x[14:10]};
      f.mant = {13'b0, 1'b1, x[9:0]};
      f.zero = (x[15:0] == 16'h0000);
    end
    return f;
  endfunction

  function automatic logic [DATA_W-1:0] fp_pack(logic prec, logic sign,
                                                logic [SP_EXP-1:0] exp,
                                                logic [SP_FRAC-1:0] frac);
    if (prec == PREC_SINGLE) return {sign, exp, frac};
    return {16'h0000, sign, exp[HP_EXP-1:0], frac[HP_FRAC-1:0]};
  endfunction

  function automatic logic [SP_EXP-1:0] exp_max(logic prec);
    return (prec == PREC_SINGLE) ? SP_EXP'(SP_EMAX) : SP_EXP'(HP_EMAX);
  endfunction

  function automatic logic [EXPT_W-1:0] exp_bias(logic prec);
    return (prec == PREC_SINGLE) ? EXPT_W'(SP_BIAS) : EXPT_W'(HP_BIAS);
  endfunction

  function automatic logic [FLAG_W-1:0] fp_flags(logic prec, logic [DATA_W-1:0] res,
                                                 logic ovf);
    logic [FLAG_W-1:0] f;
    f             = '0;
    f[FLAG_NEG]   = (prec == PREC_SINGLE) ? res[31] : res[15];
    f[FLAG_ZERO]  = (res == '0);
    f[FLAG_CARRY] = 1'b0;
    f[FLAG_OVF]   = ovf;
    return f;
  endfunction

endpackage

// File: rtl/fpu_div_if.sv
// Start/done request bus between the execute-stage controller and the divider.
interface fpu_div_if;
  import fpu_pkg::*;

  logic              start;
  logic              prec;
  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] b;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] Result;
  logic [FLAG_W-1:0] FPUFlags;

  modport master (output start, prec, a, b, input busy, done, Result, FPUFlags);
  modport slave  (input start, prec, a, b, output busy, done, Result, FPUFlags);
endinterface

// File: rtl/mant_div.sv
// Restoring significand divider: one quotient bit per step, MSB first.
module mant_div
  import fpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic              step_i,
  input  logic [MANT_W-1:0] dividend_i,
  input  logic [MANT_W-1:0] divisor_i,
  input  logic [CNT_W-1:0]  cnt_i,
  output logic [Q_W-1:0]    q_o,
  output logic              last_o
);

  logic [MANT_W:0]   rem_q, rem_d;
  logic [MANT_W-1:0] dvs_q, dvs_d;
  logic [Q_W-1:0]    quo_q, quo_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              last_q, last_d;
  logic [MANT_W:0]   diff;

  // rem stays below 2*divisor, so after a subtract or a non-subtract the
  // top bit is always clear before the shift.
  always_comb begin
    rem_d  = rem_q;
    dvs_d  = dvs_q;
    quo_d  = quo_q;
    cnt_d  = cnt_q;
    last_d = last_q;
    diff   = rem_q - {1'b0, dvs_q};
    if (load_i) begin
      rem_d  = {1'b0, dividend_i};
      dvs_d  = divisor_i;
      quo_d  = '0;
      cnt_d  = cnt_i;
      last_d = (cnt_i == CNT_W'(1));
    end else if (step_i) begin
      if (rem_q >= {1'b0, dvs_q}) begin
        rem_d = {diff[MANT_W-1:0], 1'b0};
        quo_d = {quo_q[Q_W-2:0], 1'b1};
      end else begin
        rem_d = {rem_q[MANT_W-1:0], 1'b0};
        quo_d = {quo_q[Q_W-2:0], 1'b0};
      end
      cnt_d  = cnt_q - CNT_W'(1);
      last_d = (cnt_q == CNT_W'(2));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_q  <= '0;
      dvs_q  <= '0;
      quo_q  <= '0;
      cnt_q  <= '0;
      last_q <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      dvs_q  <= dvs_d;
      quo_q  <= quo_d;
      cnt_q  <= cnt_d;
      last_q <= last_d;
    end
  end

  assign q_o    = quo_q;
  assign last_o = last_q;

endmodule

// File: rtl/fpu_div.sv
// Multi-cycle half/single floating-point divider: FSM, exponent path, special
// cases and result packing around the restoring significand divider.
module fpu_div
  import fpu_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  fpu_div_if.slave   bus
);

  div_state_e               state_q, state_d;
  logic                     prec_q, prec_d;
  logic                     sign_q, sign_d;
  logic signed [EXPT_W-1:0] expt_q, expt_d;
  logic [DATA_W-1:0]        res_q, res_d;
  logic                     ovf_q, ovf_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;
  logic [DATA_W-1:0]        result_q, result_d;
  logic [FLAG_W-1:0]        flags_q, flags_d;

  fp_fields_t               fa, fb;
  logic                     load, step, last;
  logic [Q_W-1:0]           quo;

  logic                     q_top;
  logic [SP_FRAC-1:0]       norm_frac;
  logic signed [EXPT_W-1:0] norm_exp, exp_lim;
  logic [DATA_W-1:0]        norm_res;
  logic                     norm_ovf;

  assign fa = fp_unpack(bus.prec, bus.a);
  assign fb = fp_unpack(bus.prec, bus.b);

  mant_div u_mant_div (
    .clk        (clk),
    .rst        (reset),
    .load_i     (load),
    .step_i     (step),
    .dividend_i (fa.mant),
    .divisor_i  (fb.mant),
    .cnt_i      ((bus.prec == PREC_SINGLE) ? CNT_W'(SP_FRAC + 2) : CNT_W'(HP_FRAC + 2)),
    .q_o        (quo),
    .last_o     (last)
  );

  // Quotient lies in (0.5, 2): pick the leading-one alignment, then truncate.
  always_comb begin
    q_top = (prec_q == PREC_SINGLE) ? quo[Q_W-1] : quo[HP_FRAC+1];
    if (prec_q == PREC_SINGLE) begin
      norm_frac = q_top ? quo[SP_FRAC:1] : quo[SP_FRAC-1:0];
    end else begin
      norm_frac = {13'b0, (q_top ? quo[HP_FRAC:1] : quo[HP_FRAC-1:0])};
    end
    norm_exp = q_top ? expt_q : expt_q - 10'sd1;
    exp_lim  = $signed({2'b00, exp_max(prec_q)});
    norm_res = '0;
    norm_ovf = 1'b0;
    if (norm_exp >= exp_lim) begin
      norm_res = fp_pack(prec_q, sign_q, exp_max(prec_q), '0);
      norm_ovf = 1'b1;
    end else if (norm_exp > 10'sd0) begin
      norm_res = fp_pack(prec_q, sign_q, norm_exp[SP_EXP-1:0], norm_frac);
    end
  end

  always_comb begin
    state_d  = state_q;
    prec_d   = prec_q;
    sign_d   = sign_q;
    expt_d   = expt_q;
    res_d    = res_q;
    ovf_d    = ovf_q;
    result_d = result_q;
    flags_d  = flags_q;
    load     = 1'b0;
    step     = 1'b0;
    unique case (state_q)
      IDLE: begin
        // done_q high means the previous result is being presented this cycle
        if (bus.start && !done_q) begin
          prec_d = bus.prec;
          sign_d = fa.sign ^ fb.sign;
          expt_d = $signed({2'b00, fa.exp}) - $signed({2'b00, fb.exp})
                   + $signed(exp_bias(bus.prec));
          if (fb.zero) begin
            res_d   = fp_pack(bus.prec, fa.sign ^ fb.sign, exp_max(bus.prec), '0);
            ovf_d   = 1'b1;
            state_d = DONE;
          end else if (fa.zero) begin
            res_d   = '0;
            ovf_d   = 1'b0;
            state_d = DONE;
          end else begin
            load    = 1'b1;
            state_d = DIV;
          end
        end
      end
      DIV: begin
        step = 1'b1;
        if (last) state_d = NORM;
      end
      NORM: begin
        res_d   = norm_res;
        ovf_d   = norm_ovf;
        state_d = DONE;
      end
      DONE: begin
        result_d = res_q;
        flags_d  = fp_flags(prec_q, res_q, ovf_q);
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_q == DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      prec_q   <= PREC_HALF;
      sign_q   <= 1'b0;
      expt_q   <= '0;
      res_q    <= '0;
      ovf_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      flags_q  <= '0;
    end else begin
      state_q  <= state_d;
      prec_q   <= prec_d;
      sign_q   <= sign_d;
      expt_q   <= expt_d;
      res_q    <= res_d;
      ovf_q    <= ovf_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
      flags_q  <= flags_d;
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.Result   = result_q;
  assign bus.FPUFlags = flags_q;

endmodule

// File: tb/tb_fpu_div.sv
// Scoreboard bench for fpu_div: directed operands with hand-computed quotients,
// flags and start-to-done latency; a monitor checks every done pulse.
module tb_fpu_div;
  import fpu_pkg::*;

  typedef struct {
    logic [31:0] res;
    logic [3:0]  flags;
    int          lat;
    int          start_cyc;
    string       name;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  exp_t sb_q[$];
  exp_t mon_e;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fpu_div_if bus();

  fpu_div u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding request.
  always @(posedge clk) begin
    #1;
    if (bus.done === 1'b1) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 expected 0 at cycle %0d", cyc);
      end else begin
        mon_e = sb_q.pop_front();
        check({mon_e.name, "_result"}, bus.Result, mon_e.res);
        check({mon_e.name, "_flags"}, 32'(bus.FPUFlags), 32'(mon_e.flags));
        check({mon_e.name, "_latency"}, 32'(cyc - mon_e.start_cyc), 32'(mon_e.lat));
        check({mon_e.name, "_busy_at_done"}, 32'(bus.busy), 32'd0);
      end
    end
  end

  task automatic launch(input string name, input logic p, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] res,
                        input logic [3:0] fl, input int lat);
    exp_t e;
    @(negedge clk);
    e.res = res; e.flags = fl; e.lat = lat; e.start_cyc = cyc + 1; e.name = name;
    sb_q.push_back(e);
    bus.prec  = p;
    bus.a     = a;
    bus.b     = b;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.prec  = ~p;
    bus.a     = $urandom;
    bus.b     = $urandom;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (sb_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (sb_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL timeout: got %0d pending results expected 0", sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic run(input string name, input logic p, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] res,
                     input logic [3:0] fl, input int lat);
    launch(name, p, a, b, res, fl, lat);
    drain(60);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.prec  = 1'b1;
    bus.a     = '0;
    bus.b     = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_result", bus.Result, 32'd0);
    check("rst_flags", 32'(bus.FPUFlags), 32'd0);
    reset = 1'b0;

    //  name           prec  a             b             Result        flags  lat
    run("s_6div2",     1'b1, 32'h40C00000, 32'h40000000, 32'h40400000, 4'h0, 27);
    run("s_1div3",     1'b1, 32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 4'h0, 27);
    run("h_3divm1p5",  1'b0, 32'h00004200, 32'h0000BE00, 32'h0000C000, 4'h8, 14);
    run("h_1div3",     1'b0, 32'h00003C00, 32'h00004200, 32'h00003555, 4'h0, 14);
    run("s_m6div2",    1'b1, 32'hC0C00000, 32'h40000000, 32'hC0400000, 4'h8, 27);
    run("s_1div0",     1'b1, 32'h3F800000, 32'h00000000, 32'h7F800000, 4'h1, 1);
    run("s_0div2",     1'b1, 32'h00000000, 32'h40000000, 32'h00000000, 4'h4, 1);
    run("s_0div0",     1'b1, 32'h00000000, 32'h00000000, 32'h7F800000, 4'h1, 1);
    run("h_1div0_hi",  1'b0, 32'hFFFF3C00, 32'hABCD0000, 32'h00007C00, 4'h1, 1);
    run("s_ovf",       1'b1, 32'h7F000000, 32'h3E800000, 32'h7F800000, 4'h1, 27);
    run("s_unf",       1'b1, 32'h00800000, 32'h40000000, 32'h00000000, 4'h4, 27);

    // Second start mid-division with different operands is ignored.
    launch("s_restart", 1'b1, 32'h40C00000, 32'h40000000, 32'h40400000, 4'h0, 27);
    repeat (5) @(negedge clk);
    check("restart_busy", 32'(bus.busy), 32'd1);
    bus.prec = 1'b1; bus.a = 32'h3F800000; bus.b = 32'h40400000; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    drain(60);

    // Start while done is high is ignored: no second done may follow.
    launch("s_doneign", 1'b1, 32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 4'h0, 27);
    drain(60);
    check("doneign_done_high", 32'(bus.done), 32'd1);
    bus.prec = 1'b1; bus.a = 32'h40C00000; bus.b = 32'h40000000; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (40) @(negedge clk);
    check("doneign_busy", 32'(bus.busy), 32'd0);

    // Reset mid-division aborts without a done pulse.
    bus.prec = 1'b1; bus.a = 32'h40C00000; bus.b = 32'h40000000; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (6) @(negedge clk);
    check("abort_busy_before", 32'(bus.busy), 32'd1);
    reset = 1'b1;
    #1;
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_result", bus.Result, 32'd0);
    check("abort_flags", 32'(bus.FPUFlags), 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (40) @(negedge clk);
    check("abort_no_done", 32'(bus.done), 32'd0);
    run("s_after_rst", 1'b1, 32'h40C00000, 32'h40000000, 32'h40400000, 4'h0, 27);

    repeat (5) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
